// File: rtl/sram_bridge_if.sv
// MEM-stage request/acknowledge bundle between the pipeline data port and the SRAM bridge.
// The master drives the request fields and the bridge (slave) returns data, ack and busy.
interface sram_bridge_if;
  logic        i_req;
  logic        i_we;
  logic [31:0] i_addr;
  logic [3:0]  i_bmask;
  logic [31:0] i_wdata;
  logic [31:0] o_rdata;
  logic        o_ack;
  logic        o_busy;

  modport master (
    output i_req, i_we, i_addr, i_bmask, i_wdata,
    input  o_rdata, o_ack, o_busy
  );

  modport slave (
    input  i_req, i_we, i_addr, i_bmask, i_wdata,
    output o_rdata, o_ack, o_busy
  );
endinterface

// File: rtl/sram_bridge.sv
// Splits a byte-masked 32-bit MEM-stage access into up to two 16-bit asynchronous SRAM
// beats (low half, then high half), skipping halves with no enabled bytes.
module sram_bridge #(
  parameter int BEAT_CYC = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  sram_bridge_if.slave mem_if,
  output logic [17:0] o_sram_addr,
  inout  wire  [15:0] io_sram_dq,
  output logic        o_sram_ce_n,
  output logic        o_sram_we_n,
  output logic        o_sram_oe_n,
  output logic        o_sram_lb_n,
  output logic        o_sram_ub_n
);

  localparam int CW = $clog2(BEAT_CYC);
  localparam logic [CW-1:0] LAST_CNT = CW'(BEAT_CYC - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          r_we;
  logic [16:0]   r_widx;
  logic [3:0]    r_bmask;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          w_last;
  logic          w_accept;
  logic          w_dq_oe;
  logic [15:0]   w_dq_out;
  logic          w_unused_addr;

  assign w_last        = (r_cnt == LAST_CNT);
  assign w_accept      = (r_state == IDLE) && mem_if.i_req;
  assign w_unused_addr = ^{mem_if.i_addr[31:19], mem_if.i_addr[1:0]};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = '0;
    case (r_state)
      IDLE: begin
        if (mem_if.i_req) begin
          if (|mem_if.i_bmask[1:0])      w_state_next = LO;
          else if (|mem_if.i_bmask[3:2]) w_state_next = HI;
          else                           w_state_next = DONE;
        end
      end
      LO: begin
        if (w_last) w_state_next = (|r_bmask[3:2]) ? HI : DONE;
        else        w_cnt_next   = r_cnt + 1'b1;
      end
      HI: begin
        if (w_last) w_state_next = DONE;
        else        w_cnt_next   = r_cnt + 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Request capture and read-data assembly; skipped halves keep the cleared value.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_we    <= 1'b0;
      r_widx  <= '0;
      r_bmask <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (w_accept) begin
      r_we    <= mem_if.i_we;
      r_widx  <= mem_if.i_addr[18:2];
      r_bmask <= mem_if.i_bmask;
      r_wdata <= mem_if.i_wdata;
      r_rdata <= '0;
    end else if (!r_we && w_last) begin
      if (r_state == LO) r_rdata[15:0]  <= io_sram_dq;
      if (r_state == HI) r_rdata[31:16] <= io_sram_dq;
    end
  end

  always_comb begin
    o_sram_addr = '0;
    o_sram_ce_n = 1'b1;
    o_sram_we_n = 1'b1;
    o_sram_oe_n = 1'b1;
    o_sram_lb_n = 1'b1;
    o_sram_ub_n = 1'b1;
    w_dq_oe     = 1'b0;
    w_dq_out    = '0;
    if (r_state == LO || r_state == HI) begin
      o_sram_addr = {r_widx, r_state == HI};
      o_sram_ce_n = 1'b0;
      o_sram_lb_n = (r_state == HI) ? ~r_bmask[2] : ~r_bmask[0];
      o_sram_ub_n = (r_state == HI) ? ~r_bmask[3] : ~r_bmask[1];
      if (r_we) begin
        // Count 0 is address setup; the strobe spans the remaining counts.
        w_dq_oe     = 1'b1;
        w_dq_out    = (r_state == HI) ? r_wdata[31:16] : r_wdata[15:0];
        o_sram_we_n = (r_cnt == '0);
      end else begin
        o_sram_oe_n = 1'b0;
      end
    end
  end

  assign io_sram_dq     = w_dq_oe ? w_dq_out : {16{1'bz}};
  assign mem_if.o_ack   = (r_state == DONE);
  assign mem_if.o_busy  = (r_state != IDLE);
  assign mem_if.o_rdata = r_rdata;

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge: behavioural async SRAM model on the bus, one line per
// request, hand-computed expectations for addresses, strobes, data and latency.
module tb_sram_bridge;

  logic        clk = 1'b0;
  logic        rstn;
  logic [17:0] sram_addr;
  wire  [15:0] sram_dq;
  logic        ce_n, we_n, oe_n, lb_n, ub_n;

  sram_bridge_if u_if ();

  sram_bridge #(.BEAT_CYC(2)) u_dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .mem_if      (u_if),
    .o_sram_addr (sram_addr),
    .io_sram_dq  (sram_dq),
    .o_sram_ce_n (ce_n),
    .o_sram_we_n (we_n),
    .o_sram_oe_n (oe_n),
    .o_sram_lb_n (lb_n),
    .o_sram_ub_n (ub_n)
  );

  always #5 clk = ~clk;

  // SRAM model: 1K halfwords are enough for the addresses used here.
  logic [15:0] mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_a  = '0;
  logic [15:0] pre_d  = '0;

  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[9:0]] : {16{1'bz}};

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_a] <= pre_d;
    end else if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr[9:0]][7:0]  <= sram_dq[7:0];
      if (!ub_n) mem[sram_addr[9:0]][15:8] <= sram_dq[15:8];
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int          n_edges, n_ce, n_we, n_oe, n_conf, gap, since_oe;
  bit          got_ack, gap_set;
  logic [17:0] first_addr, last_addr;
  logic [15:0] dq_first, dq_last;
  logic        lb_seen, ub_seen;
  logic [31:0] rdata_ack;

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    pre_a = a; pre_d = d; pre_we = 1'b1;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issue one request at a negedge, sample every cycle until ack.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [3:0] bm,
                        input logic [31:0] wd, input bit keep_req);
    u_if.i_req = 1'b1; u_if.i_we = we; u_if.i_addr = addr;
    u_if.i_bmask = bm; u_if.i_wdata = wd;
    n_edges = 0; n_ce = 0; n_we = 0; n_oe = 0; gap = -1; gap_set = 0;
    got_ack = 0; first_addr = '0; last_addr = '0; dq_first = '0; dq_last = '0;
    lb_seen = 1'b1; ub_seen = 1'b1; rdata_ack = '0;
    for (int k = 0; k < 40 && !got_ack; k++) begin
      @(posedge clk);
      n_edges++;
      @(negedge clk);
      if (!ce_n) begin
        n_ce++;
        if (n_ce == 1) first_addr = sram_addr;
        last_addr = sram_addr;
        lb_seen = lb_n; ub_seen = ub_n;
        if (oe_n && !gap_set) begin gap = since_oe; gap_set = 1; end
      end
      if (!we_n) begin
        n_we++;
        if (n_we == 1) dq_first = sram_dq;
        dq_last = sram_dq;
      end
      if (!oe_n) n_oe++;
      if (!oe_n && !we_n) n_conf++;
      if (!oe_n) since_oe = 0; else since_oe++;
      if (u_if.o_ack) begin got_ack = 1; rdata_ack = u_if.o_rdata; end
    end
    if (!got_ack) chk("ack_timeout", 32'd0, 32'd1);
    $display("txn we=%0b addr=%h bm=%b wdata=%h edges=%0d beats_cyc=%0d rdata=%h",
             we, addr, bm, wd, n_edges, n_ce, rdata_ack);
    if (!keep_req) begin
      u_if.i_req = 1'b0;
      @(negedge clk);
      if (!u_if.o_ack) since_oe++;
      chk("ack_one_cycle", {31'd0, u_if.o_ack}, 32'd0);
    end
  endtask

  int ack_cnt;

  initial begin
    rstn = 1'b0;
    u_if.i_req = 1'b0; u_if.i_we = 1'b0; u_if.i_addr = '0;
    u_if.i_bmask = '0; u_if.i_wdata = '0;
    since_oe = 100; n_conf = 0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {27'd0, ce_n, we_n, oe_n, lb_n, ub_n}, 32'h1F);
    chk("rst_busy_ack", {30'd0, u_if.o_busy, u_if.o_ack}, 32'd0);
    chk("rst_rdata", u_if.o_rdata, 32'd0);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Full-word write.
    do_req(1'b1, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 0);
    chk("wr_lat", n_edges, 5);
    chk("wr_addr0", {14'd0, first_addr}, 32'h82);
    chk("wr_addr1", {14'd0, last_addr}, 32'h83);
    chk("wr_dq0", {16'd0, dq_first}, 32'hBEEF);
    chk("wr_dq1", {16'd0, dq_last}, 32'hDEAD);
    chk("wr_we_cyc", n_we, 2);
    chk("wr_oe_cyc", n_oe, 0);
    chk("wr_mem", {mem[10'h83], mem[10'h82]}, 32'hDEAD_BEEF);

    // Full-word read.
    preload(10'h82, 16'h1234);
    preload(10'h83, 16'hABCD);
    do_req(1'b0, 32'h0000_0104, 4'b1111, 32'h0, 0);
    chk("rd_lat", n_edges, 5);
    chk("rd_data", rdata_ack, 32'hABCD_1234);
    chk("rd_oe_cyc", n_oe, 4);
    chk("rd_we_cyc", n_we, 0);

    // Single byte 2 write: one HI beat.
    preload(10'h5, 16'h1100);
    do_req(1'b1, 32'h0000_0008, 4'b0100, 32'h00AA_0000, 0);
    chk("b2_lat", n_edges, 3);
    chk("b2_beat_cyc", n_ce, 2);
    chk("b2_addr", {14'd0, first_addr}, 32'h5);
    chk("b2_lb_ub", {30'd0, lb_seen, ub_seen}, 32'h1);
    chk("b2_mem", {16'd0, mem[10'h5]}, 32'h11AA);

    // Low-half read: upper half stays zero, value held after DONE.
    do_req(1'b0, 32'h0000_0104, 4'b0011, 32'h0, 0);
    chk("lo_lat", n_edges, 3);
    chk("lo_beat_cyc", n_ce, 2);
    chk("lo_addr", {14'd0, first_addr}, 32'h82);
    chk("lo_data", rdata_ack, 32'h0000_1234);
    repeat (3) @(negedge clk);
    chk("lo_hold", u_if.o_rdata, 32'h0000_1234);
    chk("lo_idle_busy", {31'd0, u_if.o_busy}, 32'd0);

    // Empty mask: no SRAM activity, ack after the accepting edge, rdata cleared.
    do_req(1'b1, 32'h0000_0040, 4'b0000, 32'hFFFF_FFFF, 0);
    chk("z_lat", n_edges, 1);
    chk("z_beat_cyc", n_ce, 0);
    chk("z_rdata", rdata_ack, 32'd0);

    // Back-to-back read then write with request held.
    n_conf = 0;
    do_req(1'b0, 32'h0000_0104, 4'b1111, 32'h0, 1);
    chk("bb_rd_data", rdata_ack, 32'hABCD_1234);
    do_req(1'b1, 32'h0000_0400, 4'b1111, 32'h55AA_33CC, 0);
    chk("bb_wr_lat", n_edges, 6);
    chk("bb_gap", gap, 2);
    chk("bb_conflict", n_conf, 0);
    chk("bb_mem", {mem[10'h201], mem[10'h200]}, 32'h55AA_33CC);

    // Reset in the middle of the HI beat of a write.
    u_if.i_req = 1'b1; u_if.i_we = 1'b1; u_if.i_addr = 32'h0000_0104;
    u_if.i_bmask = 4'b1111; u_if.i_wdata = 32'h0BAD_F00D;
    begin
      bit hit = 0;
      for (int k = 0; k < 20 && !hit; k++) begin
        @(negedge clk);
        if (!ce_n && sram_addr[0]) hit = 1;
      end
      chk("rst_reach_hi", {31'd0, hit}, 32'd1);
    end
    rstn = 1'b0;
    #1;
    chk("mid_rst_strobes", {29'd0, ce_n, we_n, oe_n}, 32'h7);
    chk("mid_rst_busy", {31'd0, u_if.o_busy}, 32'd0);
    chk("mid_rst_addr", {14'd0, sram_addr}, 32'd0);
    u_if.i_req = 1'b0;
    ack_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 3) rstn = 1'b1;
      if (u_if.o_ack) ack_cnt++;
    end
    chk("mid_rst_no_ack", ack_cnt, 0);
    chk("post_rst_busy", {31'd0, u_if.o_busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
